// File: rtl/dbus_xbar_if.sv
// Data-bus bundle between the core data port, dbus_xbar and the peripheral slots.
// The master modport is the core/peripheral side; the slave modport is the crossbar itself.
interface dbus_xbar_if #(
  parameter int NSLAVE   = 5,
  parameter int SLAVE_AW = 14
);
  logic                       m_rd;
  logic [31:0]                m_raddr;
  logic [31:0]                m_rdata;
  logic                       m_wr;
  logic [31:0]                m_waddr;
  logic [31:0]                m_wdata;
  logic [3:0]                 m_wstrb;
  logic [NSLAVE-1:0]          s_rd;
  logic [NSLAVE*SLAVE_AW-1:0] s_raddr;
  logic [NSLAVE*32-1:0]       s_rdata;
  logic [NSLAVE-1:0]          s_wr;
  logic [NSLAVE*SLAVE_AW-1:0] s_waddr;
  logic [31:0]                s_wdata;
  logic [3:0]                 s_wstrb;
  logic                       err_clr;
  logic                       err_valid;
  logic [31:0]                err_addr;
  logic                       err_write;
  logic [31:0]                rd_cnt;
  logic [31:0]                wr_cnt;

  modport master (
    output m_rd, m_raddr, m_wr, m_waddr, m_wdata, m_wstrb, s_rdata, err_clr,
    input  m_rdata, s_rd, s_raddr, s_wr, s_waddr, s_wdata, s_wstrb,
           err_valid, err_addr, err_write, rd_cnt, wr_cnt
  );
  modport slave (
    input  m_rd, m_raddr, m_wr, m_waddr, m_wdata, m_wstrb, s_rdata, err_clr,
    output m_rdata, s_rd, s_raddr, s_wr, s_waddr, s_wdata, s_wstrb,
           err_valid, err_addr, err_write, rd_cnt, wr_cnt
  );
endinterface

// File: rtl/dbus_xbar.sv
// Single-master, NSLAVE-slave data-bus crossbar with decode-error capture.
// Define DBUS_XBAR_PERF_CNT_EN to build the saturating rd_cnt/wr_cnt counters.

// Per-slot address match and read-return gating.
module dbus_xbar_lane #(
  parameter int          BASEADDR_WIDTH = 8,
  parameter logic [31:0] BASE           = 32'h0
) (
  input  logic [BASEADDR_WIDTH-1:0] rtag,
  input  logic [BASEADDR_WIDTH-1:0] wtag,
  input  logic                      sel,
  input  logic [31:0]               rdata,
  output logic                      match_r,
  output logic                      match_w,
  output logic [31:0]               rterm
);
  localparam logic [BASEADDR_WIDTH-1:0] BTAG = BASE[31:32-BASEADDR_WIDTH];
  assign match_r = (rtag == BTAG);
  assign match_w = (wtag == BTAG);
  assign rterm   = rdata & {32{sel}};
endmodule

module dbus_xbar #(
  parameter int                       NSLAVE         = 5,
  parameter int                       BASEADDR_WIDTH = 8,
  parameter int                       SLAVE_AW       = 14,
  parameter logic [NSLAVE*32-1:0]     BASEADDRS      = {32'h0400_0000, 32'h0300_0000,
                                                        32'h0200_0000, 32'h0100_0000,
                                                        32'h0000_0000},
  parameter logic [NSLAVE-1:0]        RD_MASK        = 5'b10111,
  parameter logic [NSLAVE-1:0]        WR_MASK        = 5'b11110,
  parameter int                       RD_LATENCY     = 1,
  parameter logic [31:0]              DEFAULT_RDATA  = 32'h0000_0000
) (
  input  logic      clk,
  input  logic      rstn,
  dbus_xbar_if.slave bus
);
  logic [NSLAVE-1:0]                 raw_r, raw_w, hit_r, hit_w, s_rd, s_wr;
  logic [NSLAVE-1:0][31:0]           rterm;
  logic [RD_LATENCY:1][NSLAVE-1:0]   vld_pipe;
  logic [31:0]                       rd_or;
  logic                              rd_err, wr_err;

  for (genvar i = 0; i < NSLAVE; i++) begin : g_lane
    dbus_xbar_lane #(
      .BASEADDR_WIDTH (BASEADDR_WIDTH),
      .BASE           (BASEADDRS[32*i +: 32])
    ) u_lane (
      .rtag    (bus.m_raddr[31:32-BASEADDR_WIDTH]),
      .wtag    (bus.m_waddr[31:32-BASEADDR_WIDTH]),
      .sel     (vld_pipe[RD_LATENCY][i]),
      .rdata   (bus.s_rdata[32*i +: 32]),
      .match_r (raw_r[i]),
      .match_w (raw_w[i]),
      .rterm   (rterm[i])
    );
  end

  // Keep only the lowest matching index so overlapping ranges stay one-hot.
  assign hit_r = raw_r & (~raw_r + NSLAVE'(1));
  assign hit_w = raw_w & (~raw_w + NSLAVE'(1));

  assign s_rd   = {NSLAVE{bus.m_rd}} & hit_r & RD_MASK;
  assign s_wr   = {NSLAVE{bus.m_wr}} & hit_w & WR_MASK;
  assign rd_err = bus.m_rd & ~|(hit_r & RD_MASK);
  assign wr_err = bus.m_wr & ~|(hit_w & WR_MASK);

  assign bus.s_rd    = s_rd;
  assign bus.s_wr    = s_wr;
  assign bus.s_raddr = {NSLAVE{bus.m_raddr[SLAVE_AW-1:0]}};
  assign bus.s_waddr = {NSLAVE{bus.m_waddr[SLAVE_AW-1:0]}};
  assign bus.s_wdata = bus.m_wdata;
  assign bus.s_wstrb = bus.m_wstrb;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= s_rd;
      for (int k = 2; k <= RD_LATENCY; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  always_comb begin
    rd_or = '0;
    for (int i = 0; i < NSLAVE; i++) rd_or = rd_or | rterm[i];
  end

  assign bus.m_rdata = (|vld_pipe[RD_LATENCY]) ? rd_or : DEFAULT_RDATA;

  // A clear coinciding with a new error still captures it; writes win over reads.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.err_valid <= 1'b0;
      bus.err_addr  <= '0;
      bus.err_write <= 1'b0;
    end else if ((wr_err || rd_err) && (!bus.err_valid || bus.err_clr)) begin
      bus.err_valid <= 1'b1;
      bus.err_addr  <= wr_err ? bus.m_waddr : bus.m_raddr;
      bus.err_write <= wr_err;
    end else if (bus.err_clr) begin
      bus.err_valid <= 1'b0;
    end
  end

`ifdef DBUS_XBAR_PERF_CNT_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (|s_rd && rd_cnt_q != 32'hFFFF_FFFF) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (|s_wr && wr_cnt_q != 32'hFFFF_FFFF) wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign bus.rd_cnt = rd_cnt_q;
  assign bus.wr_cnt = wr_cnt_q;
`else
  assign bus.rd_cnt = '0;
  assign bus.wr_cnt = '0;
`endif
endmodule

// File: tb/tb_dbus_xbar.sv
// Directed bench for dbus_xbar: one instance at RD_LATENCY=1, one at RD_LATENCY=3,
// both driven by the same master stimulus.
module tb_dbus_xbar;
  localparam int NS = 5;
  localparam int AW = 14;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic        m_rd, m_wr, err_clr;
  logic [31:0] m_raddr, m_waddr, m_wdata;
  logic [3:0]  m_wstrb;
  // slot0 IRAM, slot1 DRAM, slot2 UART, slot3 segled, slot4 buzzer
  logic [NS*32-1:0] s_rdata = {32'h0000_0022, 32'h0000_0033, 32'h0000_0011,
                               32'hDEAD_BEEF, 32'hAAAA_0000};

  dbus_xbar_if #(.NSLAVE(NS), .SLAVE_AW(AW)) if1 ();
  dbus_xbar_if #(.NSLAVE(NS), .SLAVE_AW(AW)) if3 ();

  assign if1.m_rd = m_rd;     assign if3.m_rd = m_rd;
  assign if1.m_raddr = m_raddr; assign if3.m_raddr = m_raddr;
  assign if1.m_wr = m_wr;     assign if3.m_wr = m_wr;
  assign if1.m_waddr = m_waddr; assign if3.m_waddr = m_waddr;
  assign if1.m_wdata = m_wdata; assign if3.m_wdata = m_wdata;
  assign if1.m_wstrb = m_wstrb; assign if3.m_wstrb = m_wstrb;
  assign if1.s_rdata = s_rdata; assign if3.s_rdata = s_rdata;
  assign if1.err_clr = err_clr; assign if3.err_clr = err_clr;

  dbus_xbar #(.RD_LATENCY(1)) dut1 (.clk(clk), .rstn(rstn), .bus(if1));
  dbus_xbar #(.RD_LATENCY(3)) dut3 (.clk(clk), .rstn(rstn), .bus(if3));

`ifdef DBUS_XBAR_PERF_CNT_EN
  localparam logic [31:0] EXP_RD3 = 32'd3, EXP_WR2 = 32'd2;
`else
  localparam logic [31:0] EXP_RD3 = 32'd0, EXP_WR2 = 32'd0;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m_rd = 1'b0; m_wr = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; idle();
    m_raddr = '0; m_waddr = '0; m_wdata = '0; m_wstrb = '0;
    #1;
    check("rst_err_valid", {31'd0, if1.err_valid}, 32'd0);
    check("rst_err_addr",  if1.err_addr, 32'd0);
    check("rst_err_write", {31'd0, if1.err_write}, 32'd0);
    check("rst_rdata1",    if1.m_rdata, 32'd0);
    check("rst_rdata3",    if3.m_rdata, 32'd0);
    check("rst_rd_cnt",    if1.rd_cnt, 32'd0);
    tick(); tick();
    rstn = 1'b1;
    tick();

    // DRAM read, latency 1
    m_rd = 1'b1; m_raddr = 32'h0100_0010;
    #1;
    check("dram_s_rd",    {27'd0, if1.s_rd}, 32'h02);
    check("dram_s_raddr", {18'd0, if1.s_raddr[1*AW +: AW]}, 32'h010);
    tick(); idle();
    check("dram_rdata", if1.m_rdata, 32'hDEAD_BEEF);

    // UART then buzzer back-to-back
    tick();
    m_rd = 1'b1; m_raddr = 32'h0200_0000;
    #1;
    check("uart_s_rd", {27'd0, if1.s_rd}, 32'h04);
    tick();
    check("l1_uart", if1.m_rdata, 32'h11);
    m_raddr = 32'h0400_0000;
    #1;
    check("buz_s_rd", {27'd0, if1.s_rd}, 32'h10);
    tick(); idle();
    check("l1_buz",   if1.m_rdata, 32'h22);
    check("l3_early", if3.m_rdata, 32'h0);
    tick();
    check("l3_uart",  if3.m_rdata, 32'h11);
    check("l1_idle",  if1.m_rdata, 32'h0);
    tick();
    check("l3_buz",   if3.m_rdata, 32'h22);
    tick();
    check("l3_idle",  if3.m_rdata, 32'h0);

    // Write to read-only IRAM
    m_wr = 1'b1; m_waddr = 32'h0000_0004; m_wdata = 32'h1234_5678; m_wstrb = 4'hF;
    #1;
    check("iram_s_wr", {27'd0, if1.s_wr}, 32'h0);
    tick(); idle();
    check("werr_valid", {31'd0, if1.err_valid}, 32'd1);
    check("werr_addr",  if1.err_addr, 32'h0000_0004);
    check("werr_write", {31'd0, if1.err_write}, 32'd1);
    m_wr = 1'b1; m_waddr = 32'h0500_0000;
    tick(); idle();
    check("werr_sticky", if1.err_addr, 32'h0000_0004);
    err_clr = 1'b1;
    tick(); idle();
    check("clr_valid", {31'd0, if1.err_valid}, 32'd0);

    // Read from write-only segled
    m_rd = 1'b1; m_raddr = 32'h0300_0000;
    #1;
    check("seg_s_rd", {27'd0, if1.s_rd}, 32'h0);
    tick(); idle();
    check("seg_rdata", if1.m_rdata, 32'h0);
    check("rerr_write", {31'd0, if1.err_write}, 32'd0);
    check("rerr_addr",  if1.err_addr, 32'h0300_0000);
    err_clr = 1'b1; m_rd = 1'b1; m_raddr = 32'h0600_0000;
    tick(); idle();
    check("clrnew_valid", {31'd0, if1.err_valid}, 32'd1);
    check("clrnew_addr",  if1.err_addr, 32'h0600_0000);

    // Read error and write error together: write captured
    err_clr = 1'b1; m_rd = 1'b1; m_raddr = 32'h0700_0000;
    m_wr = 1'b1; m_waddr = 32'h0800_0000;
    tick(); idle();
    check("both_addr",  if1.err_addr, 32'h0800_0000);
    check("both_write", {31'd0, if1.err_write}, 32'd1);
    err_clr = 1'b1;
    tick(); idle();

    // Simultaneous UART write and DRAM read
    m_wr = 1'b1; m_waddr = 32'h0200_0004; m_wdata = 32'h0000_00A5; m_wstrb = 4'b0001;
    m_rd = 1'b1; m_raddr = 32'h0100_0000;
    #1;
    check("sim_s_wr",    {27'd0, if1.s_wr}, 32'h04);
    check("sim_s_rd",    {27'd0, if1.s_rd}, 32'h02);
    check("sim_wdata",   if1.s_wdata, 32'h0000_00A5);
    check("sim_wstrb",   {28'd0, if1.s_wstrb}, 32'h1);
    check("sim_s_waddr", {18'd0, if1.s_waddr[2*AW +: AW]}, 32'h004);
    tick(); idle();
    check("sim_noerr", {31'd0, if1.err_valid}, 32'd0);
    check("sim_rdata", if1.m_rdata, 32'hDEAD_BEEF);

    // Reset mid-read
    m_rd = 1'b1; m_raddr = 32'h0100_0000;
    tick(); idle();
    check("mid_rdata", if1.m_rdata, 32'hDEAD_BEEF);
    rstn = 1'b0;
    #1;
    check("mid_rst_rdata1", if1.m_rdata, 32'h0);
    check("mid_rst_rdata3", if3.m_rdata, 32'h0);
    check("mid_rst_rd_cnt", if1.rd_cnt, 32'h0);
    check("mid_rst_wr_cnt", if1.wr_cnt, 32'h0);
    tick();
    rstn = 1'b1;
    tick(); tick();
    check("mid_rst_l3_drop", if3.m_rdata, 32'h0);

    // Three reads, two writes (one overlapping cycle), then an erroring write
    m_rd = 1'b1; m_raddr = 32'h0000_0000;
    m_wr = 1'b1; m_waddr = 32'h0100_0000;
    tick();
    m_raddr = 32'h0400_0000; m_waddr = 32'h0300_0000;
    tick();
    m_wr = 1'b0; m_raddr = 32'h0200_0000;
    tick(); idle();
    m_wr = 1'b1; m_waddr = 32'h0000_0000;
    tick(); idle();
    check("cnt_rd", if1.rd_cnt, EXP_RD3);
    check("cnt_wr", if1.wr_cnt, EXP_WR2);
    err_clr = 1'b1;
    tick(); idle();
    check("cnt_rd_after_clr", if1.rd_cnt, EXP_RD3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dbus_xbar.md
Name: dbus_xbar

Overview:
- Parametrised single-master, N-slave data-bus interconnect between the RISC-V data port and the memory-mapped peripherals (IRAM read port, DRAM, UART, segment LEDs, buzzer, and any later peripherals).
- Replaces hand-instantiated per-slave read/write decoders and the fixed 4-way read mux with one block.
- Slave count, base addresses and per-slave read/write permission are set by parameters. Read latency is configurable.
- Adds decode-error capture and optional transaction counters.

Parameters:
- NSLAVE, 5: number of slave ports.
- BASEADDR_WIDTH, 8: upper address bits compared during decode.
- SLAVE_AW, 14: slave-side address width. Each slave uses only the low bits it needs.
- BASEADDRS, {32'h0400_0000,32'h0300_0000,32'h0200_0000,32'h0100_0000,32'h0000_0000}: packed NSLAVE*32 base addresses. Slave i is at bits [32*i+31:32*i].
- RD_MASK, 5'b10111: bit i=1 means slave i is readable.
- WR_MASK, 5'b11110: bit i=1 means slave i is writable.
- RD_LATENCY, 1: cycles from m_rd to valid s_rdata, range 1..4. Applies to all slaves.
- DEFAULT_RDATA, 32'h0000_0000: value returned for unmapped or non-readable reads, and when idle.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- m_rd  in  1  master read strobe
- m_raddr  in  32  master read byte address
- m_rdata  out  32  master read data, valid RD_LATENCY cycles after m_rd
- m_wr  in  1  master write strobe
- m_waddr  in  32  master write byte address
- m_wdata  in  32  master write data
- m_wstrb  in  4  master byte enables
- s_rd  out  NSLAVE  per-slave read strobe
- s_raddr  out  NSLAVE*SLAVE_AW  per-slave read address
- s_rdata  in  NSLAVE*32  per-slave read data
- s_wr  out  NSLAVE  per-slave write strobe
- s_waddr  out  NSLAVE*SLAVE_AW  per-slave write address
- s_wdata  out  32  broadcast write data
- s_wstrb  out  4  broadcast byte enables
- err_clr  in  1  clears captured decode error
- err_valid  out  1  a decode error has been captured (sticky)
- err_addr  out  32  address of the first captured error
- err_write  out  1  1 = the captured error was a write
- rd_cnt  out  32  accepted read count (optional feature)
- wr_cnt  out  32  accepted write count (optional feature)

Behaviour:
- Reset: rstn is asynchronous, active-low; clock is clk. All outputs reset as follows:
  - err_valid=0, err_addr=0, err_write=0
  - rd_cnt=0, wr_cnt=0
  - read-select pipeline cleared, so m_rdata=DEFAULT_RDATA.
- Decode (combinational): slave i hits when addr[31:32-BASEADDR_WIDTH] equals the same bits of BASEADDRS slot i. If base ranges overlap, the lowest index wins, so hit vectors are one-hot or zero.
- Read channel:
  - s_rd[i] = m_rd & hit_r[i] & RD_MASK[i], with zero added latency.
  - Every s_raddr slot carries m_raddr[SLAVE_AW-1:0].
- Write channel:
  - s_wr[i] = m_wr & hit_w[i] & WR_MASK[i].
  - Every s_waddr slot carries m_waddr[SLAVE_AW-1:0].
  - s_wdata and s_wstrb pass straight through.
- Read and write may occur in the same cycle on different or the same slaves; the channels are independent.
- Read-return path:
  - The s_rd vector enters a RD_LATENCY-deep shift register.
  - The final stage selects which s_rdata slot drives m_rdata (AND-OR mux).
  - If the final stage is all zero, m_rdata=DEFAULT_RDATA.
  - Back-to-back reads every cycle are supported with no bubbles.
- Decode error: m_rd with no permitted readable hit, or m_wr with no permitted writable hit. A read to a write-only slave counts as an error.
  - Capture occurs only when err_valid=0 (first error is kept).
  - On capture: err_valid<=1, err_addr<=offending address, err_write<=1 for a write.
  - A read error and a write error in the same cycle: the write is captured.
  - err_clr=1 clears err_valid next cycle. If err_clr and a new error coincide, the new error is captured and err_valid stays 1.
  - An erroring access drives no s_rd or s_wr strobe.
- Reset asserted mid-read: the pipeline clears immediately and the pending return data is discarded.

Optional Feature:
- Macro DBUS_XBAR_PERF_CNT_EN.
- Defined:
  - rd_cnt increments on every cycle with any s_rd bit set.
  - wr_cnt increments on every cycle with any s_wr bit set.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0.
  - err_clr does not clear them.
- Not defined: rd_cnt and wr_cnt are tied to 0 and no counter flops exist.

Test Plan:
- Read 0x0100_0010 (DRAM, slot1 returns 0xDEADBEEF), RD_LATENCY=1:
  - s_rd=5'b00010 and s_raddr slot1=0x010 in the same cycle.
  - m_rdata=0xDEADBEEF one cycle later.
- RD_LATENCY=3, reads to UART then buzzer on consecutive cycles (slots return 0x11, 0x22): m_rdata=0x11 at cycle+3 and 0x22 at cycle+4.
- Write 0x0000_0004 (IRAM, not writable):
  - s_wr=0.
  - err_valid=1, err_addr=0x0000_0004, err_write=1.
  - A second error at 0x0500_0000 leaves err_addr unchanged.
- Read 0x0300_0000 (segled, write-only):
  - s_rd=0, m_rdata=DEFAULT_RDATA next cycle, err_write=0.
  - err_clr pulsed in the same cycle as a new error at 0x0600_0000: err_valid stays 1, err_addr=0x0600_0000.
- Simultaneous write 0x0200_0004 (data 0xA5, strb 4'b0001) and read 0x0100_0000:
  - s_wr=5'b00100 and s_rd=5'b00010 in the same cycle.
  - No error flagged.
- With DBUS_XBAR_PERF_CNT_EN defined:
  - 3 reads and 2 writes give rd_cnt=3, wr_cnt=2.
  - rstn asserted mid-read gives both counters 0 and m_rdata=DEFAULT_RDATA immediately.
